// File: rtl/mul32p_pkg.sv
// Shared constants and types for the mul32p 32x32 -> 64 pipelined multiplier.
package mul32p_pkg;

    localparam int MUL_W        = 32;
    localparam int PROD_W       = 64;
    localparam int PIPE_DEPTH   = 8;

    // Row count entering each reduction level, ending at the two rows
    // handed to the final carry-propagate adder.
    localparam int DADDA_LEVELS = 8;
    localparam int DADDA_H [DADDA_LEVELS+1] = '{32, 28, 19, 13, 9, 6, 4, 3, 2};

    typedef enum logic {
        MODE_UNSIGNED = 1'b0,
        MODE_SIGNED   = 1'b1
    } mode_e;

endpackage

// File: rtl/mul32p_fa.sv
// 1-bit full adder cell of the reduction tree; tying z low turns it into a
// half adder.
module mul32p_fa (
    input  logic x,
    input  logic y,
    input  logic z,
    output logic s,
    output logic c
);

    assign s = x ^ y ^ z;
    assign c = (x & y) | (z & (x ^ y));

endmodule

// File: rtl/mul32p.sv
// mul32p: 8-stage pipelined 32x32 -> 64 multiplier, signed (Baugh-Wooley)
// or unsigned per operand pair, one result per cycle.
// Optional macro MUL32P_VALID_EN adds in_valid/out_valid, carried alongside
// the data.
// Stages: 1 operand capture, 2 partial products, 3-6 carry-save reduction
// (two levels each), 7 low half of the final adder, 8 high half.
module mul32p
    import mul32p_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
`ifdef MUL32P_VALID_EN
    input  logic              in_valid,
    output logic              out_valid,
`endif
    input  logic [MUL_W-1:0]  a,
    input  logic [MUL_W-1:0]  b,
    input  logic              mode,
    output logic [MUL_W-1:0]  hi,
    output logic [MUL_W-1:0]  lo
);

    logic [MUL_W-1:0]  a_q;
    logic [MUL_W-1:0]  b_q;
    mode_e             mode_q;
    logic [MUL_W-1:0]  pp_row;
    logic [PROD_W-1:0] pp_d [MUL_W];
    logic [PROD_W-1:0] pp_q [MUL_W];
    logic [PROD_W-1:0] fin_x_q;
    logic [PROD_W-1:0] fin_y_q;
    logic [MUL_W-1:0]  lo_q;
    logic              lo_cy_q;
    logic [MUL_W-1:0]  up_x_q;
    logic [MUL_W-1:0]  up_y_q;

    // Stage 1: capture operands together with their mode.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value regardless of block ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q    <= '0;
            b_q    <= '0;
            mode_q <= MODE_UNSIGNED;
        end else begin
            a_q    <= a;
            b_q    <= b;
            mode_q <= mode_e'(mode);
        end
    end

    // Partial-product rows; signed mode inverts the sign-crossing terms and
    // folds the Baugh-Wooley constant 2^32 + 2^63 into free bits of row 0.
    // NOTE: every always_comb output gets a default first so no path can
    // infer a latch.
    always_comb begin
        pp_row = '0;
        pp_d   = '{default: '0};
        for (int i = 0; i < MUL_W; i++) begin
            pp_row = a_q & {MUL_W{b_q[i]}};
            if (mode_q == MODE_SIGNED) begin
                if (i == MUL_W - 1) pp_row[MUL_W-2:0] = ~pp_row[MUL_W-2:0];
                else                pp_row[MUL_W-1]   = ~pp_row[MUL_W-1];
            end
            pp_d[i] = PROD_W'(pp_row) << i;
        end
        if (mode_q == MODE_SIGNED) begin
            pp_d[0][MUL_W]    = 1'b1;
            pp_d[0][PROD_W-1] = 1'b1;
        end
    end

    // Stage 2: register the partial-product array.
    // NOTE: register arrays here are pipeline state, not storage, so they are
    // cleared on reset to keep in-flight products from surviving it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) pp_q <= '{default: '0};
        else      pp_q <= pp_d;
    end

    // Row-wise carry-save reduction following the Dadda height sequence;
    // each level turns groups of three rows into a sum row and a carry row.
    for (genvar k = 0; k < DADDA_LEVELS; k++) begin : g_lvl
        localparam int HI = DADDA_H[k];
        localparam int HO = DADDA_H[k+1];
        localparam int NC = HI - HO;

        logic [PROD_W-1:0] rin  [HI];
        logic [PROD_W-1:0] rout [HO];

        if (k == 0) begin : g_src_pp
            assign rin = pp_q;
        end else if (k % 2 == 1) begin : g_src_comb
            assign rin = g_lvl[k-1].rout;
        end else begin : g_src_reg
            // Stages 3-5: pipeline cut after every second reduction level.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) rin <= '{default: '0};
                else      rin <= g_lvl[k-1].rout;
            end
        end

        for (genvar c = 0; c < NC; c++) begin : g_csa
            logic [PROD_W-1:0] sum;
            logic [PROD_W-2:0] cry;
            for (genvar i = 0; i < PROD_W - 1; i++) begin : g_bit
                mul32p_fa u_fa (
                    .x (rin[3*c][i]),
                    .y (rin[3*c+1][i]),
                    .z (rin[3*c+2][i]),
                    .s (sum[i]),
                    .c (cry[i])
                );
            end
            // A carry out of bit 63 lies outside the product, so only the sum.
            assign sum[PROD_W-1] = rin[3*c][PROD_W-1] ^ rin[3*c+1][PROD_W-1]
                                 ^ rin[3*c+2][PROD_W-1];
            assign rout[2*c]     = sum;
            assign rout[2*c+1]   = {cry, 1'b0};
        end

        for (genvar r = 3 * NC; r < HI; r++) begin : g_pass
            assign rout[r-NC] = rin[r];
        end
    end

    // Stage 6: register the two rows left after the last reduction level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fin_x_q <= '0;
            fin_y_q <= '0;
        end else begin
            fin_x_q <= g_lvl[DADDA_LEVELS-1].rout[0];
            fin_y_q <= g_lvl[DADDA_LEVELS-1].rout[1];
        end
    end

    // Stage 7: low half of the final adder; upper halves ride along.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lo_q    <= '0;
            lo_cy_q <= 1'b0;
            up_x_q  <= '0;
            up_y_q  <= '0;
        end else begin
            {lo_cy_q, lo_q} <= {1'b0, fin_x_q[MUL_W-1:0]} + {1'b0, fin_y_q[MUL_W-1:0]};
            up_x_q          <= fin_x_q[PROD_W-1:MUL_W];
            up_y_q          <= fin_y_q[PROD_W-1:MUL_W];
        end
    end

    // Stage 8: high half of the final adder; registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi <= '0;
            lo <= '0;
        end else begin
            hi <= up_x_q + up_y_q + MUL_W'(lo_cy_q);
            lo <= lo_q;
        end
    end

`ifdef MUL32P_VALID_EN
    logic [PIPE_DEPTH-1:0] vld_sr;

    // in_valid shadows the data through the same eight register stages.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) vld_sr <= '0;
        else      vld_sr <= {vld_sr[PIPE_DEPTH-2:0], in_valid};
    end

    assign out_valid = vld_sr[PIPE_DEPTH-1];
`endif

endmodule

// File: tb/tb_mul32p.sv
// Self-checking bench for mul32p: directed corner cases, LFSR and random
// streams against an arithmetic reference delayed by the pipeline depth,
// and reset behaviour with products in flight.
module tb_mul32p;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a;
    logic [31:0] b;
    logic        mode;
    logic [31:0] hi;
    logic [31:0] lo;
`ifdef MUL32P_VALID_EN
    logic        in_valid;
    logic        out_valid;
    logic        vq [$];
`endif

    logic [63:0] mq [$];
    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] la;
    logic [31:0] lb;

    always #5 clk = ~clk;

    mul32p dut (
        .clk       (clk),
        .rst       (rst),
`ifdef MUL32P_VALID_EN
        .in_valid  (in_valid),
        .out_valid (out_valid),
`endif
        .a         (a),
        .b         (b),
        .mode      (mode),
        .hi        (hi),
        .lo        (lo)
    );

    // Exact product straight from the arithmetic definition.
    function automatic logic [63:0] ref_prod(input logic [31:0] x, input logic [31:0] y,
                                             input logic m);
        longint p;
        if (m) p = longint'($signed(x)) * longint'($signed(y));
        else   p = longint'({32'b0, x} * {32'b0, y});
        return 64'(p);
    endfunction

    function automatic logic [31:0] lfsr_next(input logic [31:0] x, input logic [31:0] m);
        return x[0] ? ((x >> 1) ^ m) : (x >> 1);
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Results in flight after reset are all zero: seven slots precede the
    // first capture.
    task automatic model_reset();
        mq.delete();
        repeat (7) mq.push_back(64'd0);
`ifdef MUL32P_VALID_EN
        vq.delete();
        repeat (7) vq.push_back(1'b0);
`endif
    endtask

    // One rising edge: advance the model, then compare 1 time unit later.
    task automatic tick();
        logic [63:0] e;
`ifdef MUL32P_VALID_EN
        logic        ev;
`endif
        @(posedge clk);
        if (!rst) begin
            model_reset();
            e = '0;
`ifdef MUL32P_VALID_EN
            ev = 1'b0;
`endif
        end else begin
            mq.push_back(ref_prod(a, b, mode));
            e = mq.pop_front();
`ifdef MUL32P_VALID_EN
            vq.push_back(in_valid);
            ev = vq.pop_front();
`endif
        end
        #1;
        check("pipe", {hi, lo}, e);
`ifdef MUL32P_VALID_EN
        check("out_valid", {63'd0, out_valid}, {63'd0, ev});
`endif
    endtask

    task automatic drive(input logic [31:0] x, input logic [31:0] y, input logic m);
        a    = x;
        b    = y;
        mode = m;
    endtask

    // Single operand pair followed by zeros; compare against a known constant
    // after the eighth edge.
    task automatic directed(input string tag, input logic [31:0] x, input logic [31:0] y,
                            input logic m, input logic [63:0] expv);
        drive(x, y, m);
        tick();
        drive(32'd0, 32'd0, 1'b0);
        repeat (7) tick();
        check(tag, {hi, lo}, expv);
    endtask

    initial begin
        rst = 1'b0;
        drive(32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
`ifdef MUL32P_VALID_EN
        in_valid = 1'b1;
`endif
        model_reset();
        #1;
        check("reset_state", {hi, lo}, 64'd0);
        repeat (3) tick();
        rst = 1'b1;
`ifdef MUL32P_VALID_EN
        in_valid = 1'b0;
`endif

        // First capture reaches the output only on the eighth edge.
        drive(32'h0000_0007, 32'h0000_0009, 1'b0);
        repeat (7) tick();
        check("pre_first", {hi, lo}, 64'd0);
        tick();
        check("first_out", {hi, lo}, 64'd63);

        directed("u_max",     32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001);
        directed("s_neg1",    32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001);
        directed("s_minsq",   32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000);
        directed("s_min_max", 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 64'hC000_0000_8000_0000);
        directed("u_min_max", 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 64'h3FFF_FFFF_8000_0000);

        // Back-to-back mixed modes.
        drive(32'h8000_0000, 32'h0000_0002, 1'b0);
        tick();
        drive(32'hFFFF_FFFE, 32'h0000_0003, 1'b1);
        tick();
        drive(32'd0, 32'd0, 1'b0);
        repeat (6) tick();
        check("b2b_first", {hi, lo}, 64'h0000_0001_0000_0000);
        tick();
        check("b2b_second", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);

`ifdef MUL32P_VALID_EN
        // in_valid pattern 1,0,1 emerges eight edges later.
        in_valid = 1'b1; drive(32'd5, 32'd6, 1'b0); tick();
        in_valid = 1'b0; drive(32'd7, 32'd8, 1'b1); tick();
        in_valid = 1'b1; drive(32'd9, 32'd10, 1'b0); tick();
        in_valid = 1'b0; drive(32'd0, 32'd0, 1'b0);
        repeat (5) tick();
        check("vld_p0", {63'd0, out_valid}, 64'd1);
        tick();
        check("vld_p1", {63'd0, out_valid}, 64'd0);
        tick();
        check("vld_p2", {63'd0, out_valid}, 64'd1);
`endif

        // LFSR stream with alternating mode.
        la = 32'h0000_0001;
        lb = 32'hDEAD_BEEF;
        for (int n = 0; n < 20000; n++) begin
            drive(la, lb, n[0]);
            tick();
            la = lfsr_next(la, 32'h8020_0003);
            lb = lfsr_next(lb, 32'h8000_0063);
        end

        // Random stream with random mode.
        for (int n = 0; n < 4000; n++) begin
            drive($urandom, $urandom, 1'($urandom_range(0, 1)));
`ifdef MUL32P_VALID_EN
            in_valid = 1'($urandom_range(0, 1));
`endif
            tick();
        end

        // Fill the pipe with non-zero products, then reset mid-stream.
        for (int n = 0; n < 10; n++) begin
            drive($urandom | 32'd1, $urandom | 32'd1, 1'(n % 2));
            tick();
        end
        rst = 1'b0;
        #1;
        check("rst_async", {hi, lo}, 64'd0);
`ifdef MUL32P_VALID_EN
        check("rst_async_vld", {63'd0, out_valid}, 64'd0);
        in_valid = 1'b0;
`endif
        drive(32'd0, 32'd0, 1'b0);
        tick();
        rst = 1'b1;
        // Zero operands after release: any non-zero output is a stale product.
        repeat (10) tick();
        check("no_stale", {hi, lo}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
